br_flow_mux_rr_lock_stable: RTL

// N-to-1 flow-controlled mux with internal round-robin arbiter, optional packet lock
// (grant held from first beat to push_last), and Depth-entry registered output FIFO.
// pop_valid/pop_data/pop_last/pop_flow_id come from flops, so they are stable under backpressure.
// No combinational path from pop_ready to push_ready. Sits at NoC/fabric merge points carrying multi-beat packets.
//

---
 rtl/br_flow_mux_rr_lock_stable_if.sv | 32 +++
 rtl/br_flow_mux_rr_lock_stable.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/br_flow_mux_rr_lock_stable_if.sv
// Handshake bundle for the flow mux: NumFlows push channels in, one pop channel out.
// The mux sits on the slave modport; whatever feeds and drains it uses master.
interface br_flow_mux_rr_lock_stable_if #(
  parameter int NumFlows = 2,
  parameter int Width    = 1
);
  localparam int IdWidth = (NumFlows > 1) ? $clog2(NumFlows) : 1;

  logic [NumFlows-1:0]            push_ready;
  logic [NumFlows-1:0]            push_valid;
  logic [NumFlows-1:0][Width-1:0] push_data;
  logic [NumFlows-1:0]            push_last;
  logic                           pop_ready;
  logic                           pop_valid;
  logic [Width-1:0]               pop_data;
  logic                           pop_last;
  logic [IdWidth-1:0]             pop_flow_id;

  modport slave (
    output push_ready,
    input  push_valid, push_data, push_last,
    input  pop_ready,
    output pop_valid, pop_data, pop_last, pop_flow_id
  );

  modport master (
    input  push_ready,
    output push_valid, push_data, push_last,
    output pop_ready,
    input  pop_valid, pop_data, pop_last, pop_flow_id
  );
endinterface

// File: rtl/br_flow_mux_rr_lock_stable.sv
// N-to-1 round-robin flow mux with optional packet lock feeding a registered output FIFO.
// Pop-side outputs come straight from flops; push_ready never depends on pop_ready.
module br_flow_mux_rr_lock_stable #(
  parameter int NumFlows                  = 2,
  parameter int Width                     = 1,
  parameter int Depth                     = 2,
  parameter bit EnablePacketLock          = 1'b0,
  parameter bit EnableAssertFinalNotValid = 1'b1
) (
  input logic                         clk,
  input logic                         rst,
  br_flow_mux_rr_lock_stable_if.slave mux_if
);
  localparam int IdWidth  = (NumFlows > 1) ? $clog2(NumFlows) : 1;
  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntWidth = $clog2(Depth + 1);

  logic [IdWidth-1:0]  rrPtr_q, rrPtr_d;
  logic                lockActive_q, lockActive_d;
  logic [IdWidth-1:0]  lockId_q, lockId_d;
  logic [PtrWidth-1:0] wrPtr_q, wrPtr_d;
  logic [PtrWidth-1:0] rdPtr_q, rdPtr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic [Width-1:0]    memData_q [Depth];
  logic [IdWidth-1:0]  memId_q   [Depth];
  logic [Depth-1:0]    memLast_q;

  logic [NumFlows-1:0] grant;
  logic [NumFlows-1:0] pushReady;
  logic [IdWidth-1:0]  grantId;
  logic [IdWidth-1:0]  scanId;
  logic                space;
  logic                pushFire;
  logic                popFire;
  int                  scanIdx;

  // Scan from the lowest priority upward so the highest-priority valid flow lands last.
  always_comb begin
    grant   = '0;
    grantId = '0;
    scanIdx = 0;
    scanId  = '0;
    if (lockActive_q) begin
      grantId         = lockId_q;
      grant[lockId_q] = mux_if.push_valid[lockId_q];
    end else begin
      for (int k = NumFlows - 1; k >= 0; k--) begin
        scanIdx = int'(rrPtr_q) + k;
        if (scanIdx >= NumFlows) scanIdx = scanIdx - NumFlows;
        scanId = IdWidth'(scanIdx);
        if (mux_if.push_valid[scanId]) begin
          grant         = '0;
          grant[scanId] = 1'b1;
          grantId       = scanId;
        end
      end
    end
  end

  assign space             = count_q < CntWidth'(Depth);
  assign pushReady         = (space && !rst) ? grant : '0;
  assign pushFire          = |pushReady;
  assign popFire           = (count_q != '0) && mux_if.pop_ready;
  assign mux_if.push_ready = pushReady;

  always_comb begin
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    count_d      = count_q;
    rrPtr_d      = rrPtr_q;
    lockActive_d = lockActive_q;
    lockId_d     = lockId_q;
    if (pushFire) wrPtr_d = (wrPtr_q == PtrWidth'(Depth - 1)) ? '0 : wrPtr_q + 1'b1;
    if (popFire)  rdPtr_d = (rdPtr_q == PtrWidth'(Depth - 1)) ? '0 : rdPtr_q + 1'b1;
    if (pushFire && !popFire)      count_d = count_q + 1'b1;
    else if (!pushFire && popFire) count_d = count_q - 1'b1;
    // A beat without last opens (or keeps) the lock; a last beat releases it and rotates priority.
    if (pushFire) begin
      if (EnablePacketLock && !mux_if.push_last[grantId]) begin
        lockActive_d = 1'b1;
        lockId_d     = grantId;
      end else begin
        lockActive_d = 1'b0;
        rrPtr_d      = (grantId == IdWidth'(NumFlows - 1)) ? '0 : grantId + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr_q      <= '0;
      lockActive_q <= 1'b0;
      lockId_q     <= '0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      memLast_q    <= '0;
      for (int i = 0; i < Depth; i++) begin
        memData_q[i] <= '0;
        memId_q[i]   <= '0;
      end
    end else begin
      rrPtr_q      <= rrPtr_d;
      lockActive_q <= lockActive_d;
      lockId_q     <= lockId_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      if (pushFire) begin
        memData_q[wrPtr_q] <= mux_if.push_data[grantId];
        memLast_q[wrPtr_q] <= mux_if.push_last[grantId];
        memId_q[wrPtr_q]   <= grantId;
      end
    end
  end

  assign mux_if.pop_valid   = count_q != '0;
  assign mux_if.pop_data    = memData_q[rdPtr_q];
  assign mux_if.pop_last    = memLast_q[rdPtr_q];
  assign mux_if.pop_flow_id = memId_q[rdPtr_q];

  for (genvar g = 0; g < NumFlows; g++) begin : gPushStable
    assert property (@(posedge clk) disable iff (rst)
      mux_if.push_valid[g] && !pushReady[g] |=>
        mux_if.push_valid[g] && $stable(mux_if.push_data[g]) && $stable(mux_if.push_last[g]));
  end

  assert property (@(posedge clk) disable iff (rst)
    mux_if.pop_valid && !mux_if.pop_ready |=>
      mux_if.pop_valid && $stable(mux_if.pop_data) && $stable(mux_if.pop_last) &&
      $stable(mux_if.pop_flow_id));
  assert property (@(posedge clk) disable iff (rst) $onehot0(pushReady));
  assert property (@(posedge clk) disable iff (rst) count_q <= CntWidth'(Depth));

  cover property (@(posedge clk) disable iff (rst) lockActive_q && !mux_if.push_valid[lockId_q]);
  cover property (@(posedge clk) disable iff (rst) (count_q == CntWidth'(Depth)) && !mux_if.pop_ready);
  cover property (@(posedge clk) disable iff (rst)
    (rrPtr_q == IdWidth'(NumFlows - 1)) ##1 (rrPtr_q == '0));

  final begin
    if (EnableAssertFinalNotValid) begin
      assert (mux_if.push_valid == '0);
      assert (!mux_if.pop_valid);
    end
  end
endmodule
